fetch_sequencer: RTL and testbench

Instruction-fetch and sequencing stage of the 4-bit lab processor. It sits directly upstream of the control decoder.
- Holds the program counter, the instruction register (opcode/operand), the carry/zero flag register and the fetch/execute phase bit.
- Presents the 7-bit decoder address {opcode, C, Z, phase}.
- Consumes the decoder's 13-bit control word to advance or load the PC and to capture ALU flags.

---
 rtl/cpu4_pkg.sv | 47 ++++
 rtl/program_counter.sv | 41 ++++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu4_pkg.sv
// ---------------------------------------------------------------------------
// cpu4_pkg
// Shared definitions for the 4-bit lab processor. The fetch sequencer and the
// control decoder both import this package, so the phase encoding, the
// control-word bit positions and the opcode map are defined in one place only.
// ---------------------------------------------------------------------------
package cpu4_pkg;

  // Two-state fetch/execute sequencer. The encoding is visible to the decoder
  // as the least significant bit of its address.
  typedef enum logic {
    PHASE_FETCH = 1'b0,
    PHASE_EXEC  = 1'b1
  } phase_e;

  // Control word layout (13 bits, produced by the decoder).
  localparam int CTL_WIDTH      = 13;
  localparam int CTL_INC_PC     = 12;
  localparam int CTL_LOAD_PC    = 11;
  localparam int CTL_LOAD_A     = 10;
  localparam int CTL_LOAD_FLAGS = 9;

  // Decoder address width: {opcode[3:0], carry, zero, phase}.
  localparam int DEC_ADDR_WIDTH = 7;
  localparam int OPCODE_WIDTH   = 4;

  // Opcode map of the lab processor.
  typedef enum logic [OPCODE_WIDTH-1:0] {
    JC    = 4'd0,
    JZ    = 4'd1,
    JMP   = 4'd2,
    LDI   = 4'd3,
    LDM   = 4'd4,
    STM   = 4'd5,
    ADDI  = 4'd6,
    ADDM  = 4'd7,
    SUBI  = 4'd8,
    SUBM  = 4'd9,
    ANDI  = 4'd10,
    ANDM  = 4'd11,
    ORI   = 4'd12,
    ORM   = 4'd13,
    NANDI = 4'd14,
    NANDM = 4'd15
  } opcode_e;

endpackage : cpu4_pkg

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Program-memory address register with a parallel load that takes priority
// over increment. Increment wraps modulo 2^WIDTH without any overflow flag.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset, clears pc to 0
//   enable     - when 0 the register holds regardless of load/inc
//   load       - load load_value (wins over inc)
//   inc        - increment by one
//   load_value - jump target
//   pc         - current program counter (direct register output)
// ---------------------------------------------------------------------------
module program_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (enable) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, regardless of statement order.
      if (load) begin
        pc <= load_value;
      end else if (inc) begin
        pc <= pc + WIDTH'(1);
      end
    end
  end

endmodule : program_counter

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch and sequencing stage of the 4-bit lab processor. Holds the
// program counter, the instruction register (opcode/operand), the carry/zero
// flags and the fetch/execute phase bit, and presents the decoder address
// {opcode, carry, zero, phase}. The decoder's control word steers PC and flag
// updates. All outputs come straight from registers.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-low reset
//   enable       - when 1 state advances on the clock edge, when 0 all holds
//   program_byte - program memory data at address pc
//   control      - decoder control word (bit12 inc_pc, bit11 load_pc,
//                  bit9 load_flags; remaining bits belong to the datapath)
//   jump_addr    - branch/jump target
//   c_in, z_in   - ALU carry and zero results
//   pc           - program memory address
//   localidad    - decoder address {opcode, carry, zero, phase}
//   operand      - latched operand (immediate or RAM address)
//   phase        - 0 = fetch, 1 = execute
// ---------------------------------------------------------------------------
module fetch_sequencer
  import cpu4_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [INSTR_WIDTH-1:0]    program_byte,
  input  logic [CTL_WIDTH-1:0]      control,
  input  logic [PC_WIDTH-1:0]       jump_addr,
  input  logic                      c_in,
  input  logic                      z_in,
  output logic [PC_WIDTH-1:0]       pc,
  output logic [DEC_ADDR_WIDTH-1:0] localidad,
  output logic [INSTR_WIDTH-5:0]    operand,
  output logic                      phase
);

  phase_e                  phase_q;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    carry;
  logic                    zero;

  logic inc_pc;
  logic load_pc;
  logic load_flags;

  assign inc_pc     = control[CTL_INC_PC];
  assign load_pc    = control[CTL_LOAD_PC];
  assign load_flags = control[CTL_LOAD_FLAGS];

  // Accumulator/RAM strobes are consumed by the datapath, not here.
  logic unused_control;
  assign unused_control = ^{control[CTL_LOAD_A], control[CTL_LOAD_FLAGS-1:0]};

  program_counter #(
    .WIDTH(PC_WIDTH)
  ) u_program_counter (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (load_pc),
    .inc       (inc_pc),
    .load_value(jump_addr),
    .pc        (pc)
  );

  // Phase FSM, instruction register and flags share one clocked process.
  // An asynchronous reset in the middle of EXECUTE discards the instruction:
  // nothing is written on that edge, and the restart begins with FETCH at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= PHASE_FETCH;
      opcode  <= '0;
      operand <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else if (enable) begin
      phase_q <= (phase_q == PHASE_FETCH) ? PHASE_EXEC : PHASE_FETCH;

      if (phase_q == PHASE_FETCH) begin
        opcode  <= program_byte[INSTR_WIDTH-1 -: OPCODE_WIDTH];
        operand <= program_byte[INSTR_WIDTH-5:0];
      end

      // The decoder only raises load_flags in EXECUTE; no phase gating here.
      if (load_flags) begin
        carry <= c_in;
        zero  <= z_in;
      end
    end
  end

  assign phase     = phase_q;
  assign localidad = {opcode, carry, zero, phase_q};

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed self-checking bench for fetch_sequencer. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [7:0]  program_byte;
  logic [12:0] control;
  logic [11:0] jump_addr;
  logic        c_in;
  logic        z_in;
  logic [11:0] pc;
  logic [6:0]  localidad;
  logic [3:0]  operand;
  logic        phase;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .PC_WIDTH   (12),
    .INSTR_WIDTH(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .program_byte(program_byte),
    .control     (control),
    .jump_addr   (jump_addr),
    .c_in        (c_in),
    .z_in        (z_in),
    .pc          (pc),
    .localidad   (localidad),
    .operand     (operand),
    .phase       (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog: the bench must always terminate.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

  // One rising edge, then land on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    enable       = 1'b0;
    program_byte = 8'h00;
    control      = 13'h0000;
    jump_addr    = 12'h000;
    c_in         = 1'b0;
    z_in         = 1'b0;
    tick();
    tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 12'h000); end
    checks++; if (localidad !== 7'b0000000) begin errors++; $display("FAIL reset_localidad got %b want %b", localidad, 7'b0000000); end
    checks++; if (operand !== 4'h0) begin errors++; $display("FAIL reset_operand got %h want %h", operand, 4'h0); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL reset_phase got %b want %b", phase, 1'b0); end
    reset = 1'b1;
  endtask

  // Test plan 1: first fetch after reset.
  task automatic test_fetch();
    enable       = 1'b1;
    program_byte = 8'h4A;
    control      = 13'b1000_000_001000;
    tick();
    checks++; if (phase !== 1'b1) begin errors++; $display("FAIL fetch_phase got %b want %b", phase, 1'b1); end
    checks++; if (pc !== 12'h001) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, 12'h001); end
    checks++; if (operand !== 4'hA) begin errors++; $display("FAIL fetch_operand got %h want %h", operand, 4'hA); end
    checks++; if (localidad !== 7'b0100_001) begin errors++; $display("FAIL fetch_localidad got %b want %b", localidad, 7'b0100_001); end
  endtask

  // Test plan 2: flag capture in EXECUTE, then hold when load_flags is low.
  task automatic test_flags();
    control = 13'h0200;
    c_in    = 1'b1;
    z_in    = 1'b0;
    tick();
    checks++; if (localidad !== 7'b0100_100) begin errors++; $display("FAIL flags_load got %b want %b", localidad, 7'b0100_100); end
    // FETCH with load_flags low and opposite ALU results.
    control      = 13'h0000;
    c_in         = 1'b0;
    z_in         = 1'b1;
    program_byte = 8'h7C;
    tick();
    checks++; if (localidad !== 7'b0111_101) begin errors++; $display("FAIL flags_hold got %b want %b", localidad, 7'b0111_101); end
    checks++; if (operand !== 4'hC) begin errors++; $display("FAIL flags_operand got %h want %h", operand, 4'hC); end
    checks++; if (pc !== 12'h001) begin errors++; $display("FAIL flags_pc_hold got %h want %h", pc, 12'h001); end
  endtask

  // Test plan 3: load_pc and inc_pc together in EXECUTE, load wins.
  task automatic test_load_priority();
    control   = 13'h1800;
    jump_addr = 12'h123;
    tick();
    checks++; if (pc !== 12'h123) begin errors++; $display("FAIL prio_pc got %h want %h", pc, 12'h123); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL prio_phase got %b want %b", phase, 1'b0); end
    checks++; if (localidad !== 7'b0111_100) begin errors++; $display("FAIL prio_localidad got %b want %b", localidad, 7'b0111_100); end
  endtask

  // Test plan 4: increment from all-ones wraps to zero.
  task automatic test_wrap();
    control      = 13'h0000;
    program_byte = 8'h2B;
    tick();
    checks++; if (localidad !== 7'b0010_101) begin errors++; $display("FAIL wrap_setup_localidad got %b want %b", localidad, 7'b0010_101); end
    control   = 13'h0800;
    jump_addr = 12'hFFF;
    tick();
    checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_setup_pc got %h want %h", pc, 12'hFFF); end
    control      = 13'h1000;
    program_byte = 8'h9D;
    tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc got %h want %h", pc, 12'h000); end
    checks++; if (localidad !== 7'b1001_101) begin errors++; $display("FAIL wrap_localidad got %b want %b", localidad, 7'b1001_101); end
    checks++; if (operand !== 4'hD) begin errors++; $display("FAIL wrap_operand got %h want %h", operand, 4'hD); end
  endtask

  // Test plan 5: enable low freezes everything, including phase.
  task automatic test_enable();
    logic [7:0]  bytes [3] = '{8'hF0, 8'h3C, 8'hA5};
    logic [12:0] ctls  [3] = '{13'h1FFF, 13'h1A00, 13'h0A00};
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      program_byte = bytes[i];
      control      = ctls[i];
      jump_addr    = 12'hABC;
      c_in         = i[0];
      z_in         = ~i[0];
      tick();
      checks++; if (pc !== 12'h000) begin errors++; $display("FAIL hold_pc[%0d] got %h want %h", i, pc, 12'h000); end
      checks++; if (localidad !== 7'b1001_101) begin errors++; $display("FAIL hold_localidad[%0d] got %b want %b", i, localidad, 7'b1001_101); end
      checks++; if (operand !== 4'hD) begin errors++; $display("FAIL hold_operand[%0d] got %h want %h", i, operand, 4'hD); end
    end
    // Resume: still in EXECUTE, so the next edge returns to FETCH.
    enable  = 1'b1;
    control = 13'h1000;
    tick();
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL resume_phase got %b want %b", phase, 1'b0); end
    checks++; if (pc !== 12'h001) begin errors++; $display("FAIL resume_pc got %h want %h", pc, 12'h001); end
    checks++; if (localidad !== 7'b1001_100) begin errors++; $display("FAIL resume_localidad got %b want %b", localidad, 7'b1001_100); end
  endtask

  // Test plan 6: asynchronous reset in the middle of EXECUTE.
  task automatic test_reset_mid_exec();
    // FETCH: jump to 0x055.
    program_byte = 8'h51;
    control      = 13'h0800;
    jump_addr    = 12'h055;
    tick();
    // EXECUTE: set both flags.
    control = 13'h0200;
    c_in    = 1'b1;
    z_in    = 1'b1;
    tick();
    // FETCH: next instruction, enter EXECUTE with pc=0x055, flags=11.
    control      = 13'h0000;
    program_byte = 8'h63;
    tick();
    checks++; if (pc !== 12'h055) begin errors++; $display("FAIL midexec_setup_pc got %h want %h", pc, 12'h055); end
    checks++; if (localidad !== 7'b0110_111) begin errors++; $display("FAIL midexec_setup_localidad got %b want %b", localidad, 7'b0110_111); end
    // Control that would update PC and flags if the edge were honoured.
    control   = 13'h1A00;
    jump_addr = 12'h777;
    c_in      = 1'b0;
    z_in      = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL async_pc got %h want %h", pc, 12'h000); end
    checks++; if (localidad !== 7'b0000_000) begin errors++; $display("FAIL async_localidad got %b want %b", localidad, 7'b0000_000); end
    checks++; if (operand !== 4'h0) begin errors++; $display("FAIL async_operand got %h want %h", operand, 4'h0); end
    checks++; if (phase !== 1'b0) begin errors++; $display("FAIL async_phase got %b want %b", phase, 1'b0); end
    // Held in reset across a rising edge: nothing moves.
    tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL held_reset_pc got %h want %h", pc, 12'h000); end
    // Release, first edge is a FETCH from address 0.
    reset        = 1'b1;
    program_byte = 8'hE7;
    control      = 13'h1000;
    tick();
    checks++; if (pc !== 12'h001) begin errors++; $display("FAIL restart_pc got %h want %h", pc, 12'h001); end
    checks++; if (localidad !== 7'b1110_001) begin errors++; $display("FAIL restart_localidad got %b want %b", localidad, 7'b1110_001); end
    checks++; if (operand !== 4'h7) begin errors++; $display("FAIL restart_operand got %h want %h", operand, 4'h7); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_flags();
    test_load_priority();
    test_wrap();
    test_enable();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_sequencer
